// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and DEPTH range check for the fetch queue
package fetch_queue_pkg;

    localparam logic [31:0] NOP       = 32'h0;
    localparam int          DEPTH_MIN = 2;
    localparam int          DEPTH_MAX = 4;

    function automatic bit depth_ok(input int d);
        return (d >= DEPTH_MIN) && (d <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_queue_fifo: DEPTH x WIDTH circular buffer with enqueue, dequeue, clear and occupancy count
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 48,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic             deq,
    input  logic             clr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    // pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // next state: clear beats enqueue/dequeue; simultaneous enq+deq leaves count unchanged
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                mem_d[tail_q] = wdata;
                tail_d        = wrap_inc(tail_q);
            end
            if (deq)
                head_d = wrap_inc(head_q);
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    // storage and pointer registers; entries reset so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[head_q];
    assign count = count_q;

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(enq && !deq && !clr && count_q == CW'(DEPTH)))
        else $error("fetch_queue_fifo overflow");

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: issues pc to 1-cycle imem, queues returning words in order and hands {pc, inst} to decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_squashed counters.
module fetch_queue #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  fetch_stall,
    input  logic                  flush,
    input  logic                  id_stall,
    output logic                  id_valid,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_inst
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_squashed
`endif
);

    import fetch_queue_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("fetch_queue DEPTH must be 2..4");
    end

    logic                  req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [CW-1:0]         count;
    logic [EW-1:0]         head;
    logic [CW:0]           occ;
    logic                  deq;
    logic                  issue;

    // stall when the queue plus the in-flight read would fill every slot, so a returning word always fits
    always_comb begin
        imem_addr   = pc;
        deq         = id_valid & ~id_stall;
        occ         = (CW+1)'(count) + (CW+1)'(req_valid_q) - (CW+1)'(deq);
        fetch_stall = occ >= (CW+1)'(DEPTH);
        issue       = ~fetch_stall & ~flush;
        req_valid_d = issue;
        req_pc_d    = pc;
    end

    // decode-facing view of the head entry; instruction reads as NOP when empty
    always_comb begin
        id_valid = count != '0;
        id_pc    = head[EW-1:DATA_WIDTH];
        id_inst  = id_valid ? head[DATA_WIDTH-1:0] : DATA_WIDTH'(NOP);
    end

    // single outstanding memory read; flush drops it via issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
        end
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .enq   (req_valid_q & ~flush),
        .deq   (deq & ~flush),
        .clr   (flush),
        .wdata ({req_pc_q, imem_rdata}),
        .rdata (head),
        .count (count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;

    // count delivered instructions, and everything held or in flight when a flush hits
    always_comb begin
        perf_fetched_d  = perf_fetched_q + 32'(deq & ~flush);
        perf_squashed_d = flush ? perf_squashed_q + 32'(count) + 32'(req_valid_q) : perf_squashed_q;
    end

    // free-running 32-bit counters, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule
